// File: rtl/mips_loader_pkg.sv
// Shared types and helpers for the MIPS program loader.
//   loader_state_e  : sequencing states of the loader FSM
//   loader_status_e : completion codes reported on the status port
//   WORD_BYTES      : bytes per image word (address stride)
//   word_addr()     : byte address of image word idx, wrapping modulo 2^32
package mips_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RESET_CPU,
    RUN,
    DONE,
    TIMEOUT,
    ERROR
  } loader_state_e;

  typedef enum logic [1:0] {
    ST_NONE     = 2'b00,
    ST_OK       = 2'b01,
    ST_TIMEOUT  = 2'b10,
    ST_OVERFLOW = 2'b11
  } loader_status_e;

  localparam int unsigned WORD_BYTES = 4;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + idx * 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/loader_run_monitor.sv
// RUN-phase monitor for the program loader.
// Tracks whether the CPU has raised `active`, counts run cycles, and decides
// when the run ends (halt or timeout), capturing $v0 in the deciding cycle.
// Ports:
//   clk, rst_ni     : clock, asynchronous active-low reset
//   clear_i         : new sequence starting; clears counter and seen flag
//   run_i           : loader is in RUN this cycle
//   cpu_active_i    : CPU active flag
//   cpu_v0_i        : CPU $v0 value
//   halt_o          : run ends this cycle by CPU halt
//   timeout_o       : run ends this cycle by timeout (halt has priority)
//   cycle_count_o   : run cycles elapsed, frozen once the run ends
//   result_o        : $v0 captured in the deciding cycle
module loader_run_monitor
  import mips_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        run_i,
  input  logic        cpu_active_i,
  input  logic [31:0] cpu_v0_i,
  output logic        halt_o,
  output logic        timeout_o,
  output logic [31:0] cycle_count_o,
  output logic [31:0] result_o
);

  logic        seen_q, seen_d;
  logic [31:0] count_q, count_d;
  logic [31:0] result_q, result_d;

  // A low `active` only means halt once the CPU has been seen running;
  // the first cycles after reset release are ignored.
  assign halt_o    = run_i && seen_q && !cpu_active_i;
  assign timeout_o = run_i && !halt_o && (count_q == 32'(TIMEOUT_CYCLES));

  always_comb begin
    seen_d   = seen_q;
    count_d  = count_q;
    result_d = result_q;
    if (clear_i) begin
      seen_d  = 1'b0;
      count_d = '0;
    end else if (run_i) begin
      if (cpu_active_i) begin
        seen_d = 1'b1;
      end
      if (halt_o || timeout_o) begin
        // Counter freezes at the deciding cycle's value.
        result_d = cpu_v0_i;
      end else begin
        count_d = count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      seen_q   <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      seen_q   <= seen_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  assign cycle_count_o = count_q;
  assign result_o      = result_q;

endmodule

// File: rtl/mips_prog_loader.sv
// Hardware test-harness driver for a Harvard MIPS CPU.
// Streams a program image into instruction memory, holds the CPU in reset
// for RESET_CYCLES, runs it with clk_enable until `active` falls or a
// timeout expires, then reports status, $v0 and the run cycle count.
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   start                      : pulse to begin a load/run sequence
//   load_valid/ready/data/last : program word stream (valid/ready handshake)
//   mem_write/address/writedata: instruction-memory write port (1-cycle pulse)
//   cpu_reset, cpu_clk_enable  : CPU control pins
//   cpu_active, cpu_register_v0: CPU observation pins
//   busy, done, status         : sequence progress and completion code
//   result, cycle_count        : $v0 at halt/timeout, run cycles elapsed
module mips_prog_loader
  import mips_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'hBFC00000,
  parameter int unsigned MAX_WORDS      = 4096,
  parameter int unsigned RESET_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic        cpu_reset,
  output logic        cpu_clk_enable,
  input  logic        cpu_active,
  input  logic [31:0] cpu_register_v0,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [31:0] result,
  output logic [31:0] cycle_count
);

  loader_state_e  state_q, state_d;
  loader_status_e status_q, status_d;
  logic [31:0]    word_cnt_q, word_cnt_d;
  logic [31:0]    rst_cnt_q, rst_cnt_d;
  logic           mem_write_q, mem_write_d;
  logic [31:0]    mem_address_q, mem_address_d;
  logic [31:0]    mem_writedata_q, mem_writedata_d;

  logic clear_run;
  logic run_active;
  logic run_halt;
  logic run_timeout;

  assign run_active = (state_q == RUN);

  loader_run_monitor #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_run_monitor (
    .clk          (clk),
    .rst_ni       (reset),
    .clear_i      (clear_run),
    .run_i        (run_active),
    .cpu_active_i (cpu_active),
    .cpu_v0_i     (cpu_register_v0),
    .halt_o       (run_halt),
    .timeout_o    (run_timeout),
    .cycle_count_o(cycle_count),
    .result_o     (result)
  );

  always_comb begin
    state_d         = state_q;
    status_d        = status_q;
    word_cnt_d      = word_cnt_q;
    rst_cnt_d       = rst_cnt_q;
    mem_write_d     = 1'b0;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    clear_run       = 1'b0;

    case (state_q)
      IDLE, DONE, TIMEOUT, ERROR: begin
        if (start) begin
          state_d    = LOAD;
          status_d   = ST_NONE;
          word_cnt_d = '0;
          clear_run  = 1'b1;
        end
      end

      LOAD: begin
        // load_ready is high throughout LOAD, so valid alone means accept.
        if (load_valid) begin
          if (word_cnt_q == 32'(MAX_WORDS)) begin
            // Image does not fit: drop the word and stop without running.
            state_d  = ERROR;
            status_d = ST_OVERFLOW;
          end else begin
            mem_write_d     = 1'b1;
            mem_address_d   = word_addr(BASE_ADDR, word_cnt_q);
            mem_writedata_d = load_data;
            word_cnt_d      = word_cnt_q + 32'd1;
            if (load_last) begin
              // The registered write pulse lands in the first RESET_CPU cycle.
              state_d   = RESET_CPU;
              rst_cnt_d = '0;
            end
          end
        end
      end

      RESET_CPU: begin
        if (rst_cnt_q == 32'(RESET_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 32'd1;
        end
      end

      RUN: begin
        if (run_halt) begin
          state_d  = DONE;
          status_d = ST_OK;
        end else if (run_timeout) begin
          state_d  = TIMEOUT;
          status_d = ST_TIMEOUT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      status_q        <= ST_NONE;
      word_cnt_q      <= '0;
      rst_cnt_q       <= '0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= BASE_ADDR;
      mem_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      status_q        <= status_d;
      word_cnt_q      <= word_cnt_d;
      rst_cnt_q       <= rst_cnt_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
    end
  end

  assign load_ready     = (state_q == LOAD);
  assign mem_write      = mem_write_q;
  assign mem_address    = mem_address_q;
  assign mem_writedata  = mem_writedata_q;
  // CPU is held in reset everywhere except while running and after a clean finish.
  assign cpu_reset      = !((state_q == RUN) || (state_q == DONE) || (state_q == TIMEOUT));
  assign cpu_clk_enable = (state_q == RUN);
  assign busy           = (state_q == LOAD) || (state_q == RESET_CPU) || (state_q == RUN);
  assign done           = (state_q == DONE) || (state_q == TIMEOUT) || (state_q == ERROR);
  assign status         = status_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
module tb_mips_prog_loader;

  localparam logic [31:0] BASE = 32'hBFC00000;
  localparam int MAXW = 4;
  localparam int RC   = 2;
  localparam int TO   = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_last = 1'b0;
  logic [31:0] load_data = '0;
  logic        cpu_active = 1'b0;
  logic [31:0] cpu_register_v0 = '0;

  logic        load_ready, mem_write, cpu_reset, cpu_clk_enable, busy, done;
  logic [31:0] mem_address, mem_writedata, result, cycle_count;
  logic [1:0]  status;

  int total = 0;
  int bad = 0;

  bit          use_fixed = 1'b0;
  logic [31:0] fixed_img [0:2];

  always #5 clk = ~clk;

  mips_prog_loader #(
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW),
    .RESET_CYCLES(RC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .mem_write(mem_write), .mem_address(mem_address), .mem_writedata(mem_writedata),
    .cpu_reset(cpu_reset), .cpu_clk_enable(cpu_clk_enable),
    .cpu_active(cpu_active), .cpu_register_v0(cpu_register_v0),
    .busy(busy), .done(done), .status(status), .result(result), .cycle_count(cycle_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_ready"}, 32'(load_ready), 32'd0);
    check_val({tag, "_mwr"}, 32'(mem_write), 32'd0);
    check_val({tag, "_maddr"}, mem_address, BASE);
    check_val({tag, "_mdata"}, mem_writedata, 32'd0);
    check_val({tag, "_cpurst"}, 32'(cpu_reset), 32'd1);
    check_val({tag, "_clken"}, 32'(cpu_clk_enable), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_status"}, 32'(status), 32'd0);
    check_val({tag, "_result"}, result, 32'd0);
    check_val({tag, "_cycles"}, cycle_count, 32'd0);
  endtask

  // Streams nwords words; every accept must show up as a write one cycle later
  // at the next sequential address, except words beyond MAXW which are dropped.
  task automatic feed_words(input int nwords, input bit with_last, input int mode, output bit ok);
    int idx = 0;
    int written = 0;
    int guard = 0;
    bit toggle = 1'b0;
    bit acc;
    logic [31:0] d;
    ok = 1'b1;
    while (idx < nwords) begin
      if (guard > 200) begin
        check_val("load_stall", 32'(idx), 32'(nwords));
        ok = 1'b0;
        load_valid = 1'b0;
        load_last = 1'b0;
        return;
      end
      guard++;
      case (mode)
        0: load_valid = 1'b1;
        1: begin load_valid = toggle; toggle = !toggle; end
        default: load_valid = 1'($urandom_range(0, 1));
      endcase
      d = (use_fixed && idx < 3) ? fixed_img[idx] : $urandom;
      load_data = d;
      load_last = with_last && (idx == nwords - 1);
      check_val("load_ready", 32'(load_ready), 32'd1);
      acc = load_valid;
      tick;
      if (acc) begin
        if (written < MAXW) begin
          check_val("wr_strobe", 32'(mem_write), 32'd1);
          check_val("wr_addr", mem_address, BASE + 32'(4 * written));
          check_val("wr_data", mem_writedata, d);
          written++;
        end else begin
          check_val("ovf_nowrite", 32'(mem_write), 32'd0);
        end
        idx++;
      end else begin
        check_val("gap_nowrite", 32'(mem_write), 32'd0);
      end
    end
    load_valid = 1'b0;
    load_last = 1'b0;
  endtask

  // One full sequence. CPU model: active is high during run cycles [a, a+l),
  // v0 = v0base + v0step*j in run cycle j. The run ends at the first low cycle
  // after being high, or at TO cycles, whichever comes first (halt on a tie).
  task automatic run_seq(input int nwords, input int mode, input int a, input int l,
                         input logic [31:0] v0base, input logic [31:0] v0step, input bit poke_start);
    bit ok;
    int halt_idx;
    int dec;
    bit exp_ok;
    start = 1'b1;
    tick;
    start = 1'b0;
    check_val("start_busy", 32'(busy), 32'd1);
    check_val("start_done", 32'(done), 32'd0);
    check_val("start_status", 32'(status), 32'd0);
    check_val("start_cycles", cycle_count, 32'd0);
    feed_words(nwords, 1'b1, mode, ok);
    if (!ok) return;
    for (int k = 0; k < RC; k++) begin
      check_val("hold_cpurst", 32'(cpu_reset), 32'd1);
      check_val("hold_clken", 32'(cpu_clk_enable), 32'd0);
      tick;
    end
    halt_idx = (l > 0) ? (a + l) : 32'h4000_0000;
    exp_ok = (halt_idx <= TO);
    dec = exp_ok ? halt_idx : TO;
    for (int j = 0; j <= dec; j++) begin
      check_val("run_clken", 32'(cpu_clk_enable), 32'd1);
      cpu_active = (j >= a) && (j < a + l);
      cpu_register_v0 = v0base + v0step * 32'(j);
      if (poke_start && j == 1) start = 1'b1;
      tick;
      start = 1'b0;
    end
    cpu_active = 1'b0;
    check_val("end_clken", 32'(cpu_clk_enable), 32'd0);
    check_val("end_cpurst", 32'(cpu_reset), 32'd0);
    check_val("end_busy", 32'(busy), 32'd0);
    check_val("end_done", 32'(done), 32'd1);
    check_val("end_status", 32'(status), exp_ok ? 32'd1 : 32'd2);
    check_val("end_result", result, v0base + v0step * 32'(dec));
    check_val("end_cycles", cycle_count, 32'(dec));
    tick;
    check_val("after_done", 32'(done), 32'd1);
    check_val("after_clken", 32'(cpu_clk_enable), 32'd0);
    $display("seq words=%0d mode=%0d a=%0d l=%0d status=%0d result=%h cycles=%0d",
             nwords, mode, a, l, status, result, cycle_count);
  endtask

  initial begin
    bit ok;
    fixed_img[0] = 32'h24020005;
    fixed_img[1] = 32'h00000008;
    fixed_img[2] = 32'h00000000;

    // Reset state, with a stray stream word that must be ignored.
    load_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    reset = 1'b1;
    tick;
    check_val("idle_ready", 32'(load_ready), 32'd0);
    tick;
    check_val("idle_nowrite", 32'(mem_write), 32'd0);
    check_val("idle_busy", 32'(busy), 32'd0);
    load_valid = 1'b0;
    tick;

    // Directed 3-word image, halt after 7 run cycles with v0=5.
    use_fixed = 1'b1;
    run_seq(3, 0, 1, 6, 32'd5, 32'd0, 1'b0);
    use_fixed = 1'b0;

    // Toggled valid, start pulse during RUN, restart after DONE.
    run_seq(4, 1, 2, 10, $urandom, 32'd1, 1'b1);

    // Never deasserts active -> timeout at TO.
    run_seq(2, 0, 1, 1000, $urandom, 32'd3, 1'b0);

    // Halt exactly at the timeout cycle: halt wins.
    run_seq(1, 0, 3, TO - 3, $urandom, 32'd1, 1'b0);

    // Active never rises -> timeout.
    run_seq(1, 2, 1, 0, $urandom, 32'd7, 1'b0);

    // Overflow: 5 words without last into a 4-word image.
    start = 1'b1;
    tick;
    start = 1'b0;
    feed_words(5, 1'b0, 0, ok);
    check_val("ovf_done", 32'(done), 32'd1);
    check_val("ovf_status", 32'(status), 32'd3);
    check_val("ovf_busy", 32'(busy), 32'd0);
    check_val("ovf_ready", 32'(load_ready), 32'd0);
    load_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check_val("ovf_cpurst", 32'(cpu_reset), 32'd1);
      check_val("ovf_clken", 32'(cpu_clk_enable), 32'd0);
      tick;
      check_val("ovf_nowr", 32'(mem_write), 32'd0);
    end
    load_valid = 1'b0;
    $display("seq overflow status=%0d done=%0d", status, done);

    // Restart from ERROR.
    run_seq(2, 2, 1, 4, $urandom, 32'd1, 1'b0);

    // Reset mid-LOAD after 2 words, then a 1-word image starts again at BASE.
    start = 1'b1;
    tick;
    start = 1'b0;
    feed_words(2, 1'b0, 0, ok);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    tick;
    check_reset_vals("midrst_hold");
    @(negedge clk);
    reset = 1'b1;
    tick;
    run_seq(1, 0, 1, 3, $urandom, 32'd1, 1'b0);

    // Randomized sequences.
    for (int r = 0; r < 6; r++) begin
      run_seq($urandom_range(1, MAXW), 2, $urandom_range(1, 3), $urandom_range(0, 55),
              $urandom, $urandom_range(0, 9), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finished", total);
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/mips_prog_loader.md
Name: mips_prog_loader

Overview:
- Drives the CPU side of a Harvard-CPU test harness in hardware: streams a program image into instruction memory, sequences CPU reset and clk_enable, then monitors `active` until halt.
- Captures register_v0 and the cycle count when the CPU halts, and flags timeout or image overflow.
- Sits between a word-stream source (host, UART bridge or bench) and the instruction-memory write port plus CPU control pins.

Parameters:
BASE_ADDR, 32'hBFC00000, byte address of first image word (CPU reset vector)
MAX_WORDS, 4096, image capacity in 32-bit words
RESET_CYCLES, 2, cycles cpu_reset is held high after load completes (min 1)
TIMEOUT_CYCLES, 10000, max cycles from clk_enable until active must fall

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  single-cycle pulse, begins a load/run sequence
load_valid  input  1  stream word valid
load_ready  output  1  loader can accept a word
load_data  input  32  program word
load_last  input  1  marks final image word
mem_write  output  1  instruction-memory write strobe
mem_address  output  32  byte address of write
mem_writedata  output  32  word written
cpu_reset  output  1  active-high reset to CPU
cpu_clk_enable  output  1  CPU clock enable
cpu_active  input  1  CPU active flag
cpu_register_v0  input  32  CPU $v0 value
busy  output  1  sequence in progress
done  output  1  high in DONE/TIMEOUT/ERROR until next start
status  output  2  00 none, 01 halted ok, 10 timeout, 11 overflow
result  output  32  v0 captured at halt
cycle_count  output  32  cycles from clk_enable to halt/timeout

Behaviour:
- Reset values: load_ready=0, mem_write=0, mem_address=BASE_ADDR, mem_writedata=0, cpu_reset=1, cpu_clk_enable=0, busy=0, done=0, status=00, result=0, cycle_count=0; state IDLE.
- Reset mid-operation aborts immediately to IDLE with the reset values; partial image is not rolled back.
- IDLE:
  - start -> LOAD; word counter cleared; done=0, status=00.
- LOAD:
  - load_ready=1.
  - Accept on load_valid&&load_ready.
  - The cycle after acceptance: mem_write=1 (single-cycle pulse), mem_address=BASE_ADDR+4*count, mem_writedata=load_data. Latency is exactly 1 cycle.
  - Back-to-back accepts yield back-to-back writes.
  - Address wraps modulo 2^32; no saturation.
  - Accepted word with load_last -> RESET_CPU after its write pulse is issued.
  - Overflow: a word accepted when count==MAX_WORDS is not written -> ERROR, status=11.
- RESET_CPU:
  - cpu_reset=1 for exactly RESET_CYCLES cycles, then 0 -> RUN.
  - cpu_clk_enable=1 from the first RUN cycle onward.
- RUN:
  - cycle_count increments every cycle from 0.
  - cpu_active is ignored until first seen high (CPU needs a cycle after reset).
  - After that, active==0 -> DONE: result<=cpu_register_v0 sampled that cycle; status=01; cpu_clk_enable=0.
  - cycle_count reaching TIMEOUT_CYCLES (even if active never rose) -> TIMEOUT: status=10, cpu_clk_enable=0, result=cpu_register_v0 at that cycle.
  - Halt and timeout in the same cycle: halt wins.
- DONE / TIMEOUT / ERROR:
  - done=1; cpu_reset stays 0 except in ERROR, where it is 1.
  - start -> LOAD, clearing done/status/cycle_count.
- busy=1 in LOAD, RESET_CPU, RUN.
- start while busy is ignored.
- load_valid outside LOAD is ignored (load_ready=0).

Decomposition:
- Package mips_loader_pkg holds:
  - state enum: IDLE, LOAD, RESET_CPU, RUN, DONE, TIMEOUT, ERROR
  - status codes: ST_NONE, ST_OK, ST_TIMEOUT, ST_OVERFLOW
  - word-size constant 4
- One sub-module, loader_run_monitor, holds the RUN-phase logic: active-seen flag, cycle counter, timeout compare, v0 capture. The top module holds the FSM and the write path.

Test Plan:
- 3-word image (0x24020005, 0x00000008, 0x00000000, last on 3rd), CPU model drops active after 7 cycles with v0=5 -> writes at 0xBFC00000/04/08 one cycle after each accept; cpu_reset high 2 cycles; done=1, status=01, result=5, cycle_count=7.
- load_valid toggled every other cycle -> mem_write pulses track accepts with exactly 1-cycle latency; no duplicate or skipped addresses.
- MAX_WORDS=4, stream 5 words without last -> 4 writes, 5th not written, status=11, cpu_reset stays 1, cpu_clk_enable never asserts.
- CPU model never deasserts active, TIMEOUT_CYCLES=50 -> status=10 at cycle_count=50; cpu_clk_enable=0 the next cycle.
- reset pulled low mid-LOAD after 2 words, released, new start with 1-word image -> write at BASE_ADDR again; all outputs at reset values while reset=0.
- start pulses during RUN ignored; start after DONE re-enters LOAD with done=0, status=00, cycle_count=0.
